// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared money widths, coin encodings and dispenser state encoding
package vending_pkg;

  localparam int MONEY_W = 8;
  localparam int DENOM_N = 5;
  localparam int VALUE_W = 6;

  typedef logic [MONEY_W-1:0] money_t;
  typedef logic [DENOM_N-1:0] denom_t;
  typedef logic [VALUE_W-1:0] value_t;

  // One-hot coin order matches the money inputs: 1, 5, 10, 20, 50.
  localparam denom_t DENOM_1  = 5'b00001;
  localparam denom_t DENOM_5  = 5'b00010;
  localparam denom_t DENOM_10 = 5'b00100;
  localparam denom_t DENOM_20 = 5'b01000;
  localparam denom_t DENOM_50 = 5'b10000;

  localparam value_t VALUE_1  = 6'd1;
  localparam value_t VALUE_5  = 6'd5;
  localparam value_t VALUE_10 = 6'd10;
  localparam value_t VALUE_20 = 6'd20;
  localparam value_t VALUE_50 = 6'd50;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EMIT,
    ST_GAP,
    ST_DONE
  } disp_state_t;

  function automatic value_t denom_value(input denom_t d);
    case (d)
      DENOM_1:  return VALUE_1;
      DENOM_5:  return VALUE_5;
      DENOM_10: return VALUE_10;
      DENOM_20: return VALUE_20;
      DENOM_50: return VALUE_50;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request/status bundle of the change dispenser (coin_cnt with CHANGE_COIN_CNT_EN)
interface change_dispenser_if;
  import vending_pkg::*;

  logic   start;
  logic   abort;
  money_t change_in;
  logic   busy;
  logic   done;
  logic   coin_strobe;
  denom_t coin_denom;
  money_t remaining;
`ifdef CHANGE_COIN_CNT_EN
  logic [4*DENOM_N-1:0] coin_cnt;

  modport master (
    output start, abort, change_in,
    input  busy, done, coin_strobe, coin_denom, remaining, coin_cnt
  );
  modport slave (
    input  start, abort, change_in,
    output busy, done, coin_strobe, coin_denom, remaining, coin_cnt
  );
`else
  modport master (
    output start, abort, change_in,
    input  busy, done, coin_strobe, coin_denom, remaining
  );
  modport slave (
    input  start, abort, change_in,
    output busy, done, coin_strobe, coin_denom, remaining
  );
`endif
endinterface

// File: rtl/change_coin_select.sv
// rtl/change_coin_select.sv - picks the largest coin not exceeding the amount still owed
module change_coin_select
  import vending_pkg::*;
(
  input  money_t remaining,
  output denom_t denom,
  output value_t value
);

  always_comb begin
    denom = '0;
    if (remaining >= money_t'(VALUE_50))      denom = DENOM_50;
    else if (remaining >= money_t'(VALUE_20)) denom = DENOM_20;
    else if (remaining >= money_t'(VALUE_10)) denom = DENOM_10;
    else if (remaining >= money_t'(VALUE_5))  denom = DENOM_5;
    else if (remaining != '0)                 denom = DENOM_1;
  end

  assign value = denom_value(denom);

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin-by-coin change dispenser (per-coin counters with CHANGE_COIN_CNT_EN)
module change_dispenser
  import vending_pkg::*;
#(
  parameter int GAP_CYCLES = 50_000_000
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  change_dispenser_if.slave bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_STEP = GAP_W'(1);

  disp_state_t      state, state_nxt;
  money_t           remaining, remaining_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             busy, done, coin_strobe;
  logic             busy_nxt, done_nxt, strobe_nxt;
  denom_t           coin_denom, denom_nxt;
  denom_t           sel_denom;
  value_t           sel_value;

  change_coin_select u_select (
    .remaining (remaining),
    .denom     (sel_denom),
    .value     (sel_value)
  );

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    gap_cnt_nxt   = gap_cnt;
    if (state != ST_IDLE && bus.abort) begin
      state_nxt     = ST_IDLE;
      remaining_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            remaining_nxt = bus.change_in;
            state_nxt     = (bus.change_in == '0) ? ST_DONE : ST_SELECT;
          end
        end
        ST_SELECT: state_nxt = ST_EMIT;
        ST_EMIT: begin
          // Selection is still valid here: remaining is unchanged since SELECT.
          remaining_nxt = remaining - money_t'(sel_value);
          if (remaining_nxt == '0) begin
            state_nxt = ST_DONE;
          end else begin
            gap_cnt_nxt = GAP_LOAD;
            state_nxt   = ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state_nxt = ST_SELECT;
          else               gap_cnt_nxt = gap_cnt - GAP_STEP;
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
    // Status outputs are registered copies of what the next state implies.
    busy_nxt   = (state_nxt != ST_IDLE);
    done_nxt   = (state_nxt == ST_DONE);
    strobe_nxt = (state_nxt == ST_EMIT);
    denom_nxt  = strobe_nxt ? sel_denom : coin_denom;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      gap_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      coin_strobe <= 1'b0;
      coin_denom  <= '0;
    end else begin
      state       <= state_nxt;
      remaining   <= remaining_nxt;
      gap_cnt     <= gap_cnt_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      coin_strobe <= strobe_nxt;
      coin_denom  <= denom_nxt;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.coin_strobe = coin_strobe;
  assign bus.coin_denom  = coin_denom;
  assign bus.remaining   = remaining;

`ifdef CHANGE_COIN_CNT_EN
  logic [4*DENOM_N-1:0] coin_cnt;
  logic                 accept;

  assign accept = (state == ST_IDLE) && bus.start;

  // Saturating 4-bit tallies, bumped together with the strobe they count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      coin_cnt <= '0;
    end else if (accept) begin
      coin_cnt <= '0;
    end else if (strobe_nxt) begin
      for (int i = 0; i < DENOM_N; i++) begin
        if (sel_denom[i] && coin_cnt[4*i +: 4] != 4'hF)
          coin_cnt[4*i +: 4] <= coin_cnt[4*i +: 4] + 4'd1;
      end
    end
  end

  assign bus.coin_cnt = coin_cnt;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed and randomized checks of change_dispenser against a greedy change model
module tb_change_dispenser;

  localparam int G      = 3;
  localparam int PERIOD = G + 2;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  change_dispenser_if dif ();

  change_dispenser #(.GAP_CYCLES(G)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int bit_of(input int v);
    case (v)
      1:       return 0;
      5:       return 1;
      10:      return 2;
      20:      return 3;
      default: return 4;
    endcase
  endfunction

  // Drives one request and checks every output cycle by cycle. Index idx counts
  // cycles after the edge that sampled start; coins come from greedy division.
  task automatic run_case(input string name, input int amount, input bit with_abort,
                          input int restart_idx, input int abort_idx);
    int  coins[$];
    int  strobe_at[$];
    int  denoms[5] = '{50, 20, 10, 5, 1};
    int  amt = amount;
    int  done_idx, stop_idx, end_idx;
    bit  aborted;
    foreach (denoms[k]) begin
      repeat (amt / denoms[k]) coins.push_back(denoms[k]);
      amt = amt % denoms[k];
    end
    foreach (coins[i]) strobe_at.push_back(2 + i * PERIOD);
    done_idx = (coins.size() == 0) ? 1 : strobe_at[coins.size()-1] + 1;
    aborted  = (abort_idx > 0) && (abort_idx < done_idx);
    stop_idx = aborted ? abort_idx : done_idx;
    end_idx  = stop_idx + 2;

    @(negedge clk);
    dif.start     = 1'b1;
    dif.change_in = 8'(amount);
    dif.abort     = with_abort;
    for (int idx = 1; idx <= end_idx; idx++) begin
      int exp_rem;
      int exp_coin;
      int cnt[5];
      logic [31:0] exp_cnt;
      @(negedge clk);
      exp_rem  = amount;
      exp_coin = 0;
      cnt      = '{default: 0};
      foreach (strobe_at[i]) begin
        if (strobe_at[i] <= stop_idx) begin
          if (strobe_at[i] == idx) exp_coin = coins[i];
          if (strobe_at[i] < idx)  exp_rem -= coins[i];
          if (strobe_at[i] <= idx) cnt[bit_of(coins[i])]++;
        end
      end
      if (aborted && idx > abort_idx) exp_rem = 0;
      check($sformatf("%s busy@%0d", name, idx), 32'(dif.busy), 32'(idx <= stop_idx));
      check($sformatf("%s done@%0d", name, idx), 32'(dif.done), 32'(!aborted && idx == done_idx));
      check($sformatf("%s strobe@%0d", name, idx), 32'(dif.coin_strobe), 32'(exp_coin != 0));
      check($sformatf("%s remaining@%0d", name, idx), 32'(dif.remaining), exp_rem);
      if (exp_coin != 0)
        check($sformatf("%s denom@%0d", name, idx), 32'(dif.coin_denom), 1 << bit_of(exp_coin));
`ifdef CHANGE_COIN_CNT_EN
      exp_cnt = '0;
      for (int b = 0; b < 5; b++) exp_cnt |= 32'((cnt[b] > 15) ? 15 : cnt[b]) << (4 * b);
      check($sformatf("%s coin_cnt@%0d", name, idx), 32'(dif.coin_cnt), exp_cnt);
`else
      exp_cnt = 32'(cnt[0]);
`endif
      dif.start = (idx == restart_idx);
      dif.abort = (idx == abort_idx);
      if (idx == restart_idx) dif.change_in = 8'd99;
    end
    dif.start = 1'b0;
    dif.abort = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    dif.start     = 1'b0;
    dif.abort     = 1'b0;
    dif.change_in = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(dif.busy), 0);
    check("reset done", 32'(dif.done), 0);
    check("reset strobe", 32'(dif.coin_strobe), 0);
    check("reset denom", 32'(dif.coin_denom), 0);
    check("reset remaining", 32'(dif.remaining), 0);
    rst_n = 1'b1;

    run_case("c88", 88, 1'b0, 0, 0);
    run_case("zero", 0, 1'b0, 0, 0);
    run_case("c255", 255, 1'b0, 0, 0);
    run_case("abort88", 88, 1'b0, 0, 8);
    run_case("after_abort7", 7, 1'b0, 0, 0);
    run_case("restart30", 30, 1'b0, 4, 0);
    run_case("start_abort42", 42, 1'b1, 0, 0);
    run_case("idle_abort6", 6, 1'b0, 0, 9);

    // Asynchronous reset while the first coin of 88 is being strobed.
    @(negedge clk);
    dif.start     = 1'b1;
    dif.change_in = 8'd88;
    @(negedge clk);
    dif.start = 1'b0;
    @(negedge clk);
    check("pre_reset strobe", 32'(dif.coin_strobe), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset busy", 32'(dif.busy), 0);
    check("async_reset strobe", 32'(dif.coin_strobe), 0);
    check("async_reset remaining", 32'(dif.remaining), 0);
    check("async_reset denom", 32'(dif.coin_denom), 0);
    check("async_reset done", 32'(dif.done), 0);
`ifdef CHANGE_COIN_CNT_EN
    check("async_reset coin_cnt", 32'(dif.coin_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 8; n++) begin
      int amount;
      int abort_at;
      amount   = $urandom_range(0, 255);
      abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      run_case($sformatf("rand%0d_%0d", n, amount), amount, 1'($urandom_range(0, 1)), 0, abort_at);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream consumer of state_transitions' change_money result; dispenses change as a timed sequence of single-coin strobes.
- On a start pulse, latches the change amount.
- Greedily decomposes the amount into 50/20/10/5/1 denominations and emits one coin per slot.
- Reports busy/done status and the running remainder, for display_design and LED_display.

Parameters:
GAP_CYCLES, 50_000_000, idle sys_clk cycles between coin strobes (0.5 s at 100 MHz); legal range >= 1.

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request (debounced key_filter-style pulse) to dispense change_in
abort  input  1  single-cycle request to stop dispensing immediately
change_in  input  8  change amount in yuan, 0..255
busy  output  1  high from start acceptance until return to IDLE
done  output  1  single-cycle pulse when dispensing completes normally
coin_strobe  output  1  single-cycle pulse, one per coin dispensed
coin_denom  output  5  one-hot coin type, valid only with coin_strobe; bit0=1, bit1=5, bit2=10, bit3=20, bit4=50 (same order as the money inputs)
remaining  output  8  change still owed after the coins already strobed

Behaviour:
- Reset (async, sys_rst_n=0): state=IDLE; busy, done, coin_strobe = 0; coin_denom, remaining = 0; gap counter = 0.
- Reset mid-dispense aborts at once. No done pulse; remaining clears.
- All outputs are registered. Cycle t below is the clock edge at which an input is sampled.
- IDLE: busy=0.
  - start=1 and change_in>0: remaining<=change_in, busy<=1, go SELECT (state in cycle t+1).
  - start=1 and change_in==0: go DONE; done=1 in cycle t+1; no strobe.
- SELECT: one cycle. Pick the largest denomination <= remaining (50, 20, 10, 5, 1 in that priority). Go EMIT.
- EMIT: one cycle with coin_strobe=1 and coin_denom=selected one-hot; remaining<=remaining-value, visible the next cycle.
  - If the new remaining is 0, go DONE.
  - Otherwise load the gap counter and go GAP.
- GAP: count GAP_CYCLES cycles, then go SELECT.
  - First strobe is in cycle t+2.
  - Strobe-to-strobe period is GAP_CYCLES+2 cycles.
- DONE: one cycle with done=1 and busy=1. Go IDLE, where busy=0.
- start while busy=1 is ignored; change_in is not re-sampled.
- abort=1 in any state other than IDLE wins over every other transition: next state IDLE, remaining=0, no done pulse, no strobe. abort in IDLE has no effect.
- start and abort together in IDLE: start is accepted.
- Arithmetic: the subtraction never underflows, because the selected value is always <= remaining. Worst case 255 = five 50s + one 5.
- coin_denom holds its last value between strobes; consumers qualify it with coin_strobe.

Optional Feature:
Macro CHANGE_COIN_CNT_EN.
- Defined: adds output coin_cnt [19:0] with 4 bits per denomination in coin_denom bit order ([3:0]=1 ... [19:16]=50).
  - Each field increments on a strobe of its denomination and saturates at 15.
  - All fields clear on start acceptance and on reset; they hold after done or abort.
- Undefined: the port and its counters are absent; all other behaviour is identical.

Decomposition:
- Shared package vending_pkg:
  - denomination one-hot constants and their values (1, 5, 10, 20, 50)
  - the dispenser state encoding (IDLE, SELECT, EMIT, GAP, DONE)
  - width constants: money width 8, denomination count 5
- One combinational sub-module, change_coin_select: takes remaining [7:0] and returns the one-hot denom plus its value [5:0].

Test Plan:
- GAP_CYCLES=3, start with change_in=88: strobes 50, 20, 10, 5, 1, 1, 1; remaining after each strobe 38, 18, 8, 3, 2, 1, 0; strobes spaced exactly 5 cycles apart; first strobe 2 cycles after start; single done one cycle after the last strobe; busy falls the following cycle.
- change_in=0 start: done pulses in cycle t+1; no coin_strobe; busy=1 only during DONE.
- change_in=255: five 50 strobes then one 5; no underflow; remaining ends at 0.
- abort during GAP after the second coin of 88 (remaining=18): next cycle IDLE, remaining=0, busy=0, no done; a following start with 7 dispenses 5, 1, 1.
- start pulsed during dispensing of 30 with change_in=99: ignored; sequence stays 20, 10.
- sys_rst_n pulled low asynchronously mid-EMIT: outputs clear without waiting for a clock edge. With CHANGE_COIN_CNT_EN, after 88 completes coin_cnt shows 50:1, 20:1, 10:1, 5:1, 1:3.
